mem_arbiter: RTL

Request arbiter and sequencer in front of the byte-serial memory controller. Buffers one pending request each from instruction fetch, load (LSB) and committed store (ROB), and issues exactly one request at a time as a one-cycle enable pulse. Tracks the in-flight request until the controller releases busy, and returns registered completion pulses to the owning requester. Applies fixed priority store > load > fetch, with a starvation guard for fetch.

---
 rtl/mem_arbiter_if.sv | 76 +++++++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the request sources, the memory controller and mem_arbiter.
// slave = arbiter side, master = environment (sources + controller).
interface mem_arbiter_if #(
    parameter int XLEN = 32,
    parameter int OP_W = 6,
    parameter int ID_W = 4
);
    logic            rdy;
    logic            flush;

    logic            if_req_valid;
    logic [XLEN-1:0] if_req_addr;
    logic            if_req_ready;

    logic            ld_req_valid;
    logic [OP_W-1:0] ld_req_op;
    logic [XLEN-1:0] ld_req_addr;
    logic [ID_W-1:0] ld_req_id;
    logic            ld_req_ready;

    logic            st_req_valid;
    logic [OP_W-1:0] st_req_op;
    logic [XLEN-1:0] st_req_addr;
    logic [XLEN-1:0] st_req_val;
    logic            st_req_ready;

    logic            mc_busy;
    logic            mc_inst_ready;
    logic            mc_data_ready;
    logic [XLEN-1:0] mc_inst;
    logic [XLEN-1:0] mc_data;

    logic            arb_if_en;
    logic [XLEN-1:0] arb_if_addr;
    logic            arb_ld_en;
    logic [OP_W-1:0] arb_ld_op;
    logic [XLEN-1:0] arb_ld_addr;
    logic [ID_W-1:0] arb_ld_id;
    logic            arb_st_en;
    logic [OP_W-1:0] arb_st_op;
    logic [XLEN-1:0] arb_st_addr;
    logic [XLEN-1:0] arb_st_val;

    logic            if_done;
    logic [XLEN-1:0] if_done_inst;
    logic            ld_done;
    logic [XLEN-1:0] ld_done_data;
    logic [ID_W-1:0] ld_done_id;
    logic            st_done;

    modport slave (
        input  rdy, flush,
        input  if_req_valid, if_req_addr,
        input  ld_req_valid, ld_req_op, ld_req_addr, ld_req_id,
        input  st_req_valid, st_req_op, st_req_addr, st_req_val,
        input  mc_busy, mc_inst_ready, mc_data_ready, mc_inst, mc_data,
        output if_req_ready, ld_req_ready, st_req_ready,
        output arb_if_en, arb_if_addr,
        output arb_ld_en, arb_ld_op, arb_ld_addr, arb_ld_id,
        output arb_st_en, arb_st_op, arb_st_addr, arb_st_val,
        output if_done, if_done_inst, ld_done, ld_done_data, ld_done_id, st_done
    );

    modport master (
        output rdy, flush,
        output if_req_valid, if_req_addr,
        output ld_req_valid, ld_req_op, ld_req_addr, ld_req_id,
        output st_req_valid, st_req_op, st_req_addr, st_req_val,
        output mc_busy, mc_inst_ready, mc_data_ready, mc_inst, mc_data,
        input  if_req_ready, ld_req_ready, st_req_ready,
        input  arb_if_en, arb_if_addr,
        input  arb_ld_en, arb_ld_op, arb_ld_addr, arb_ld_id,
        input  arb_st_en, arb_st_op, arb_st_addr, arb_st_val,
        input  if_done, if_done_inst, ld_done, ld_done_data, ld_done_id, st_done
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/load/store arbiter in front of the byte-serial memory controller:
// one buffered request per source, one issue at a time, registered completions.
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int OP_W         = 6,
    parameter int ID_W         = 4,
    parameter int STARVE_LIMIT = 4
) (
    input logic            clk,
    input logic            rst,
    mem_arbiter_if.slave   bus
);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUED, S_BUSY} state_t;
    typedef enum logic [1:0] {SRC_IF, SRC_LD, SRC_ST} src_t;

    state_t state, state_nx;
    src_t   cur_src, cur_src_nx;

    logic            if_v, ld_v, st_v;
    logic [XLEN-1:0] if_addr, ld_addr, st_addr, st_val;
    logic [OP_W-1:0] ld_op, st_op;
    logic [ID_W-1:0] ld_id;
    logic [3:0]      starve_cnt, starve_nx;

    logic gnt_if, gnt_ld, gnt_st;
    logic if_done_nx, ld_done_nx, st_done_nx;
    logic if_acc, ld_acc, st_acc;

    assign bus.if_req_ready = !if_v;
    assign bus.ld_req_ready = !ld_v;
    assign bus.st_req_ready = !st_v;

    assign if_acc = bus.if_req_valid && !if_v && !bus.flush;
    assign ld_acc = bus.ld_req_valid && !ld_v && !bus.flush;
    assign st_acc = bus.st_req_valid && !st_v && !bus.flush;

    always_comb begin
        state_nx   = state;
        cur_src_nx = cur_src;
        gnt_if     = 1'b0;
        gnt_ld     = 1'b0;
        gnt_st     = 1'b0;
        if_done_nx = 1'b0;
        ld_done_nx = 1'b0;
        st_done_nx = 1'b0;

        case (state)
            S_IDLE: begin
                if (!bus.flush && (if_v || ld_v || st_v)) begin
                    if (if_v && starve_cnt == STARVE_MAX) gnt_if = 1'b1;
                    else if (st_v)                        gnt_st = 1'b1;
                    else if (ld_v)                        gnt_ld = 1'b1;
                    else                                  gnt_if = 1'b1;
                    state_nx   = S_ISSUED;
                    cur_src_nx = gnt_st ? SRC_ST : (gnt_ld ? SRC_LD : SRC_IF);
                end
            end
            S_ISSUED: state_nx = S_BUSY;
            S_BUSY: begin
                if (!bus.mc_busy) begin
                    state_nx   = S_IDLE;
                    st_done_nx = (cur_src == SRC_ST);
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (state != S_IDLE && !bus.flush) begin
            if_done_nx = (cur_src == SRC_IF) && bus.mc_inst_ready;
            ld_done_nx = (cur_src == SRC_LD) && bus.mc_data_ready;
        end

        // flush aborts a fetch/load in flight; a store always runs to completion
        if (bus.flush && state != S_IDLE && cur_src != SRC_ST)
            state_nx = S_IDLE;

        if (bus.flush || !if_v || gnt_if)
            starve_nx = '0;
        else if ((gnt_ld || gnt_st) && starve_cnt != STARVE_MAX)
            starve_nx = starve_cnt + 4'd1;
        else
            starve_nx = starve_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            cur_src          <= SRC_IF;
            starve_cnt       <= '0;
            if_v             <= 1'b0;
            ld_v             <= 1'b0;
            st_v             <= 1'b0;
            bus.arb_if_en    <= 1'b0;
            bus.arb_if_addr  <= '0;
            bus.arb_ld_en    <= 1'b0;
            bus.arb_ld_op    <= '0;
            bus.arb_ld_addr  <= '0;
            bus.arb_ld_id    <= '0;
            bus.arb_st_en    <= 1'b0;
            bus.arb_st_op    <= '0;
            bus.arb_st_addr  <= '0;
            bus.arb_st_val   <= '0;
            bus.if_done      <= 1'b0;
            bus.if_done_inst <= '0;
            bus.ld_done      <= 1'b0;
            bus.ld_done_data <= '0;
            bus.ld_done_id   <= '0;
            bus.st_done      <= 1'b0;
        end else if (bus.rdy) begin
            state      <= state_nx;
            cur_src    <= cur_src_nx;
            starve_cnt <= starve_nx;

            bus.arb_if_en <= gnt_if;
            bus.arb_ld_en <= gnt_ld;
            bus.arb_st_en <= gnt_st;
            if (gnt_if) bus.arb_if_addr <= if_addr;
            if (gnt_ld) begin
                bus.arb_ld_op   <= ld_op;
                bus.arb_ld_addr <= ld_addr;
                bus.arb_ld_id   <= ld_id;
            end
            if (gnt_st) begin
                bus.arb_st_op   <= st_op;
                bus.arb_st_addr <= st_addr;
                bus.arb_st_val  <= st_val;
            end

            // arb_ld_id doubles as the in-flight load tag
            bus.if_done <= if_done_nx;
            bus.ld_done <= ld_done_nx;
            bus.st_done <= st_done_nx;
            if (if_done_nx) bus.if_done_inst <= bus.mc_inst;
            if (ld_done_nx) begin
                bus.ld_done_data <= bus.mc_data;
                bus.ld_done_id   <= bus.arb_ld_id;
            end

            if (bus.flush || gnt_if) if_v <= 1'b0;
            else if (if_acc) begin
                if_v    <= 1'b1;
                if_addr <= bus.if_req_addr;
            end

            if (bus.flush || gnt_ld) ld_v <= 1'b0;
            else if (ld_acc) begin
                ld_v    <= 1'b1;
                ld_op   <= bus.ld_req_op;
                ld_addr <= bus.ld_req_addr;
                ld_id   <= bus.ld_req_id;
            end

            if (gnt_st) st_v <= 1'b0;
            else if (st_acc) begin
                st_v    <= 1'b1;
                st_op   <= bus.st_req_op;
                st_addr <= bus.st_req_addr;
                st_val  <= bus.st_req_val;
            end
        end
    end
endmodule
